// File: rtl/symbol_decoder_pkg.sv
// Shared definitions for the symbol LUT decoder: default parameters,
// table entry layout and escape FSM states.
package symbol_decoder_pkg;

   localparam int CODE_W_DEF = 8;
   localparam int SYM_W_DEF  = 16;
   localparam int CNT_W_DEF  = 32;

   // Table entry as written through tbl_wdata: {vld, esc, symbol}.
   typedef struct packed {
      logic                 vld;
      logic                 esc;
      logic [SYM_W_DEF-1:0] symbol;
   } lut_entry_t;

   // NORMAL decodes through the table; ESC passes the next code through raw.
   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_ESC    = 1'b1
   } esc_state_t;

endpackage

// File: rtl/symbol_lut_ram.sv
// Decode table storage: one synchronous write port, one synchronous
// read port with read-before-write behaviour. Only the vld bits are
// reset; esc and symbol fields come up undefined until programmed.
module symbol_lut_ram
   import symbol_decoder_pkg::*;
#(
   parameter int AW = CODE_W_DEF,
   parameter int DW = SYM_W_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW+1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW+1:0] rd_data
);

   localparam int DEPTH = 2 ** AW;

   logic [DW:0]      mem [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DW:0]      rd_payload;
   logic             rd_vld;

   // Payload array and its read register; the read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data[DW:0];
      end
      if (rd_en) begin
         rd_payload <= mem[rd_addr];
      end
   end

   // Valid bits live in resettable flops so a reset empties the table.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q  <= '0;
         rd_vld <= 1'b0;
      end else begin
         if (we) begin
            vld_q[wr_addr] <= wr_data[DW+1];
         end
         if (rd_en) begin
            rd_vld <= vld_q[rd_addr];
         end
      end
   end

   assign rd_data = {rd_vld, rd_payload};

endmodule

// File: rtl/symbol_lut_decoder.sv
// Two-stage table-driven symbol decoder with an escape mechanism.
// S1 holds the code and its table entry (the RAM read register is the
// S1 entry register); S2 runs the escape FSM and holds the outputs.
module symbol_lut_decoder
   import symbol_decoder_pkg::*;
#(
   parameter int CODE_W = CODE_W_DEF,
   parameter int SYM_W  = SYM_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              tbl_we,
   input  logic [CODE_W-1:0] tbl_addr,
   input  logic [SYM_W+1:0]  tbl_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SYM_W-1:0]  out_symbol,
   output logic              out_raw,
   output logic              out_err,
   output logic [CNT_W-1:0]  sym_count,
   output logic [15:0]       err_count
);

   logic              s1_valid;
   logic [CODE_W-1:0] s1_code;
   logic [SYM_W+1:0]  s1_entry;
   logic              s1_advance;
   logic              s2_advance;
   logic              accept;
   logic              take;
   logic              fire;
   esc_state_t        state_q;
   esc_state_t        state_d;
   logic              dec_emit;
   logic [SYM_W-1:0]  dec_symbol;
   logic              dec_raw;
   logic              dec_err;

   // Raw escaped codes are zero-extended, or truncated when wider than a symbol.
   function automatic logic [SYM_W-1:0] raw_symbol(input logic [CODE_W-1:0] code);
      return SYM_W'(code);
   endfunction

   assign s2_advance = !out_valid || out_ready;
   assign s1_advance = !s1_valid || s2_advance;
   assign in_ready   = s1_advance && !flush;
   assign accept     = in_valid && in_ready;
   assign take       = s2_advance && s1_valid;
   assign fire       = out_valid && out_ready;

   // ---- Stage 1: capture code and look up its entry ----
   symbol_lut_ram #(
      .AW (CODE_W),
      .DW (SYM_W)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (tbl_we),
      .wr_addr (tbl_addr),
      .wr_data (tbl_wdata),
      .rd_en   (s1_advance),
      .rd_addr (in_code),
      .rd_data (s1_entry)
   );

   // S1 occupancy; flush empties it on the next edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (s1_advance) begin
         s1_valid <= accept;
      end
   end

   // S1 code register, held while the stage is stalled.
   always_ff @(posedge clk) begin
      if (s1_advance) begin
         s1_code <= in_code;
      end
   end

   // ---- Stage 2: escape FSM decode decision and output registers ----
   // Next-state and decode result for the item currently in S1.
   always_comb begin
      state_d    = state_q;
      dec_emit   = 1'b0;
      dec_symbol = '0;
      dec_raw    = 1'b0;
      dec_err    = 1'b0;
      case (state_q)
         ST_NORMAL: begin
            if (!s1_entry[SYM_W+1]) begin
               dec_emit = 1'b1;
               dec_err  = 1'b1;
            end else if (!s1_entry[SYM_W]) begin
               dec_emit   = 1'b1;
               dec_symbol = s1_entry[SYM_W-1:0];
            end else begin
               state_d = ST_ESC;
            end
         end
         ST_ESC: begin
            dec_emit   = 1'b1;
            dec_raw    = 1'b1;
            dec_symbol = raw_symbol(s1_code);
            state_d    = ST_NORMAL;
         end
         default: begin
            state_d = ST_NORMAL;
         end
      endcase
   end

   // Escape state only moves when S2 actually consumes an item.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_NORMAL;
      end else if (flush) begin
         state_q <= ST_NORMAL;
      end else if (take) begin
         state_q <= state_d;
      end
   end

   // Output register: loads on an emitting take, holds while stalled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_symbol <= '0;
         out_raw    <= 1'b0;
         out_err    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (s2_advance) begin
         out_valid <= s1_valid && dec_emit;
         if (s1_valid && dec_emit) begin
            out_symbol <= dec_symbol;
            out_raw    <= dec_raw;
            out_err    <= dec_err;
         end
      end
   end

   // Accepted-output counters; the error counter sticks at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sym_count <= '0;
         err_count <= '0;
      end else if (fire) begin
         sym_count <= sym_count + CNT_W'(1);
         if (out_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_symbol_lut_decoder.sv
// Directed bench for symbol_lut_decoder: hand-computed expectations for
// error, table, escape, stall, write-collision and flush behaviour.
module tb_symbol_lut_decoder;
   import symbol_decoder_pkg::*;

   localparam int CW = 8;
   localparam int SW = 16;
   localparam int NW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_code;
   logic          tbl_we;
   logic [CW-1:0] tbl_addr;
   logic [SW+1:0] tbl_wdata;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_symbol;
   logic          out_raw;
   logic          out_err;
   logic [NW-1:0] sym_count;
   logic [15:0]   err_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [31:0] obs_q[$];
   int          obs_cyc[$];
   logic [31:0] exp_q[$];
   logic        stall_seen = 1'b0;
   logic [31:0] stall_val;

   always #5 clk = ~clk;

   symbol_lut_decoder #(
      .CODE_W (CW),
      .SYM_W  (SW),
      .CNT_W  (NW)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_code    (in_code),
      .tbl_we     (tbl_we),
      .tbl_addr   (tbl_addr),
      .tbl_wdata  (tbl_wdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_symbol (out_symbol),
      .out_raw    (out_raw),
      .out_err    (out_err),
      .sym_count  (sym_count),
      .err_count  (err_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack_out();
      return {14'd0, out_raw, out_err, out_symbol};
   endfunction

   function automatic logic [31:0] ev(input logic raw, input logic err, input logic [15:0] s);
      return {14'd0, raw, err, s};
   endfunction

   function automatic lut_entry_t ent(input logic v, input logic e, input logic [15:0] s);
      lut_entry_t x;
      x.vld    = v;
      x.esc    = e;
      x.symbol = s;
      return x;
   endfunction

   always @(posedge clk) cyc++;

   // Output monitor: records accepted outputs and checks stalled outputs hold.
   always @(negedge clk) begin
      if (!reset_n) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_hold", pack_out(), stall_val);
         end
         if (out_valid && out_ready) begin
            obs_q.push_back(pack_out());
            obs_cyc.push_back(cyc);
         end
         stall_seen = out_valid && !out_ready;
         stall_val  = pack_out();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_code   = '0;
      tbl_we    = 1'b0;
      tbl_addr  = '0;
      tbl_wdata = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out", pack_out(), 32'd0);
      chk("rst_sym_count", sym_count, 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      obs_q.delete();
      obs_cyc.delete();
   endtask

   task automatic tbl_write(input logic [CW-1:0] a, input lut_entry_t e);
      tbl_we    = 1'b1;
      tbl_addr  = a;
      tbl_wdata = e;
      tick();
      tbl_we = 1'b0;
   endtask

   task automatic feed(input logic [CW-1:0] c);
      in_valid = 1'b1;
      in_code  = c;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int guard;

      // Unprogrammed code yields an error output two cycles after acceptance.
      do_reset();
      in_valid = 1'b1;
      in_code  = 8'h05;
      tick();
      in_valid = 1'b0;
      chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
      tick();
      chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
      chk("err_out", pack_out(), ev(1'b0, 1'b1, 16'h0000));
      tick();
      chk("err_drain", {31'd0, out_valid}, 32'd0);
      chk("err_count", 32'(err_count), 32'd1);
      chk("err_sym_count", sym_count, 32'd1);

      // Back-to-back stream of one programmed code.
      do_reset();
      tbl_write(8'h10, ent(1'b1, 1'b0, 16'hBEEF));
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_code  = 8'h10;
         tick();
      end
      in_valid = 1'b0;
      repeat (4) tick();
      chk("b2b_count", obs_q.size(), 32'd8);
      for (int i = 0; i < obs_q.size(); i++) begin
         chk("b2b_sym", obs_q[i], ev(1'b0, 1'b0, 16'hBEEF));
         if (i > 0) chk("b2b_consec", obs_cyc[i] - obs_cyc[i-1], 32'd1);
      end
      chk("b2b_sym_count", sym_count, 32'd8);

      // Escape marker followed by a code that is passed through raw.
      do_reset();
      tbl_write(8'h7F, ent(1'b1, 1'b1, 16'h0000));
      tbl_write(8'h22, ent(1'b1, 1'b0, 16'h1234));
      in_valid = 1'b1;
      in_code  = 8'h7F;
      tick();
      in_code = 8'h7F;
      tick();
      in_code = 8'h22;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("esc_count", obs_q.size(), 32'd2);
      if (obs_q.size() == 2) begin
         chk("esc_raw", obs_q[0], ev(1'b1, 1'b0, 16'h007F));
         chk("esc_next", obs_q[1], ev(1'b0, 1'b0, 16'h1234));
      end
      chk("esc_sym_count", sym_count, 32'd2);

      // Table write coincident with a lookup of the same entry.
      do_reset();
      tbl_write(8'h33, ent(1'b1, 1'b0, 16'h5555));
      tbl_we    = 1'b1;
      tbl_addr  = 8'h33;
      tbl_wdata = ent(1'b1, 1'b0, 16'hAAAA);
      in_valid  = 1'b1;
      in_code   = 8'h33;
      tick();
      tbl_we = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("rbw_count", obs_q.size(), 32'd2);
      if (obs_q.size() == 2) begin
         chk("rbw_old", obs_q[0], ev(1'b0, 1'b0, 16'h5555));
         chk("rbw_new", obs_q[1], ev(1'b0, 1'b0, 16'hAAAA));
      end

      // Continuous stream with random backpressure; order and count preserved.
      do_reset();
      for (int c = 0; c < 16; c++) begin
         tbl_write(8'(c), ent(1'b1, 1'b0, 16'h1000 + 16'(c) * 16'h0101));
      end
      exp_q.delete();
      for (int i = 0; i < 40; i++) begin
         exp_q.push_back(ev(1'b0, 1'b0, 16'h1000 + 16'(i % 16) * 16'h0101));
      end
      sent  = 0;
      guard = 0;
      while (sent < 40 && guard < 2000) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = 1'b1;
         in_code   = 8'(sent % 16);
         @(negedge clk);
         if (in_ready) sent++;
         @(posedge clk);
         #1;
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (obs_q.size() < 40 && guard < 100) begin
         tick();
         guard++;
      end
      chk("bp_sent", sent, 32'd40);
      chk("bp_count", obs_q.size(), 32'd40);
      for (int i = 0; i < obs_q.size() && i < 40; i++) begin
         chk("bp_order", obs_q[i], exp_q[i]);
      end
      chk("bp_sym_count", sym_count, 32'd40);

      // Flush while in ESC with an item in S1 and another being offered.
      do_reset();
      tbl_write(8'h10, ent(1'b1, 1'b0, 16'hBEEF));
      tbl_write(8'h7F, ent(1'b1, 1'b1, 16'h0000));
      tbl_write(8'h22, ent(1'b1, 1'b0, 16'h1234));
      in_valid = 1'b1;
      in_code  = 8'h10;
      tick();
      in_code = 8'h7F;
      tick();
      in_code = 8'h22;
      tick();
      in_code   = 8'h55;
      flush     = 1'b1;
      tbl_we    = 1'b1;
      tbl_addr  = 8'h44;
      tbl_wdata = ent(1'b1, 1'b0, 16'h4444);
      @(negedge clk);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      chk("flush_pre_count", sym_count, 32'd1);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      tbl_we   = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      repeat (3) tick();
      chk("flush_sym_count", sym_count, 32'd1);
      chk("flush_err_count", 32'(err_count), 32'd0);
      feed(8'h7F);
      repeat (3) tick();
      chk("flush_esc_drop", sym_count, 32'd1);
      feed(8'h22);
      repeat (3) tick();
      feed(8'h44);
      repeat (4) tick();
      chk("flush_count", obs_q.size(), 32'd3);
      if (obs_q.size() == 3) begin
         chk("flush_first", obs_q[0], ev(1'b0, 1'b0, 16'hBEEF));
         chk("flush_raw", obs_q[1], ev(1'b1, 1'b0, 16'h0022));
         chk("flush_tbl_wr", obs_q[2], ev(1'b0, 1'b0, 16'h4444));
      end
      chk("flush_final_count", sym_count, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
